// File: rtl/lmsm_sequencer.sv
// Load-multiple / store-multiple sequencer: walks a register mask in ascending order,
// moving one word per accepted cycle between the 8 x 16-bit register file and data memory.
module lmsm_sequencer (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        is_sm,
    input  logic [7:0]  mask,
    input  logic [15:0] base_addr,
    output logic        busy,
    output logic        done,
    output logic        pc_loaded,
    output logic [2:0]  rf_addr,
    output logic        rf_wr_en,
    output logic [15:0] rf_wdata,
    input  logic [15:0] rf_rdata,
    output logic [15:0] mem_addr,
    output logic        mem_rd_en,
    output logic        mem_wr_en,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        mem_ready
);

    // state   | meaning
    // IDLE    | waiting for a request from decode
    // XFER    | one register/memory word per accepted cycle
    // DONE    | one-cycle completion pulse, then back to IDLE
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  pending_q, pending_d;
    logic [15:0] addr_q, addr_d;
    logic        is_sm_q, is_sm_d;
    logic        pc_ld_q, pc_ld_d;
    logic [2:0]  cur;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            pending_q <= 8'h00;
            addr_q    <= 16'h0000;
            is_sm_q   <= 1'b0;
            pc_ld_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            addr_q    <= addr_d;
            is_sm_q   <= is_sm_d;
            pc_ld_q   <= pc_ld_d;
        end
    end

    // Lowest set bit wins, so registers go out R0 first.
    always_comb begin
        cur = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (pending_q[i]) cur = 3'(i);
        end
    end

    assign rf_wdata  = mem_rdata;
    assign mem_wdata = rf_rdata;

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        addr_d    = addr_q;
        is_sm_d   = is_sm_q;
        pc_ld_d   = pc_ld_q;
        busy      = 1'b0;
        done      = 1'b0;
        pc_loaded = 1'b0;
        rf_addr   = 3'd0;
        mem_addr  = 16'h0000;
        rf_wr_en  = 1'b0;
        mem_rd_en = 1'b0;
        mem_wr_en = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    is_sm_d   = is_sm;
                    pending_d = mask;
                    addr_d    = base_addr;
                    pc_ld_d   = !is_sm && mask[0];
                    state_d   = (mask != 8'h00) ? ST_XFER : ST_DONE;
                end
            end
            ST_XFER: begin
                busy      = 1'b1;
                rf_addr   = cur;
                mem_addr  = addr_q;
                // Strobes are masked while reset is applied so the aborting edge commits nothing.
                mem_rd_en = !is_sm_q && rst;
                mem_wr_en = is_sm_q && rst;
                rf_wr_en  = !is_sm_q && mem_ready && rst;
                if (mem_ready) begin
                    pending_d = pending_q & ~(8'b1 << cur);
                    addr_d    = addr_q + 16'd1;
                    if (pending_d == 8'h00) state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                busy      = 1'b1;
                done      = 1'b1;
                pc_loaded = pc_ld_q;
                state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_lmsm_sequencer.sv
// Directed bench for lmsm_sequencer: behavioural RF/memory models plus a transfer scoreboard.
module tb_lmsm_sequencer;

    logic        clk = 1'b0;
    logic        rst, start, is_sm, mem_ready;
    logic [7:0]  mask;
    logic [15:0] base_addr;
    logic        busy, done, pc_loaded, rf_wr_en, mem_rd_en, mem_wr_en;
    logic [2:0]  rf_addr;
    logic [15:0] rf_wdata, rf_rdata, mem_addr, mem_wdata, mem_rdata;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic        sm;
        logic [2:0]  ra;
        logic [15:0] ma;
        logic [15:0] data;
    } exp_t;
    exp_t sbq[$];

    bit [15:0] rf_m [8];
    bit        rf_seen [8];
    bit [15:0] mem_m [65536];
    bit        mem_seen [65536];

    always #5 clk = ~clk;

    lmsm_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .is_sm(is_sm), .mask(mask),
        .base_addr(base_addr), .busy(busy), .done(done), .pc_loaded(pc_loaded),
        .rf_addr(rf_addr), .rf_wr_en(rf_wr_en), .rf_wdata(rf_wdata), .rf_rdata(rf_rdata),
        .mem_addr(mem_addr), .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    function automatic logic [15:0] pat(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'h3C5A;
    endfunction

    function automatic logic [15:0] rf_val(input logic [2:0] i);
        return rf_seen[i] ? rf_m[i] : (16'h1000 + 16'(i));
    endfunction

    function automatic logic [15:0] mem_val(input logic [15:0] a);
        return mem_seen[a] ? mem_m[a] : pat(a);
    endfunction

    assign rf_rdata  = rf_val(rf_addr);
    assign mem_rdata = mem_val(mem_addr);

    always @(posedge clk) begin
        if (rf_wr_en) begin
            rf_m[rf_addr]    <= rf_wdata;
            rf_seen[rf_addr] <= 1'b1;
        end
        if (mem_wr_en && mem_ready) begin
            mem_m[mem_addr]    <= mem_wdata;
            mem_seen[mem_addr] <= 1'b1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic push_expected(input logic sm, input logic [7:0] m, input logic [15:0] b);
        logic [15:0] a;
        exp_t e;
        a = b;
        for (int i = 0; i < 8; i++) begin
            if (m[i]) begin
                e.sm   = sm;
                e.ra   = 3'(i);
                e.ma   = a;
                e.data = sm ? rf_val(3'(i)) : pat(a);
                sbq.push_back(e);
                a = a + 16'd1;
            end
        end
    endtask

    // Called at the negedge: any active strobe must match the oldest pending transfer.
    task automatic monitor();
        exp_t e;
        if (mem_rd_en || mem_wr_en || rf_wr_en) begin
            if (sbq.size() == 0) begin
                chk("unexpected_strobe", {29'd0, mem_rd_en, mem_wr_en, rf_wr_en}, 32'd0);
            end else begin
                e = sbq[0];
                chk("rf_addr", {29'd0, rf_addr}, {29'd0, e.ra});
                chk("mem_addr", {16'd0, mem_addr}, {16'd0, e.ma});
                chk("mem_rd_en", {31'd0, mem_rd_en}, {31'd0, !e.sm});
                chk("mem_wr_en", {31'd0, mem_wr_en}, {31'd0, e.sm});
                chk("rf_wr_en", {31'd0, rf_wr_en}, {31'd0, !e.sm && mem_ready});
                if (mem_ready) begin
                    if (e.sm) chk("mem_wdata", {16'd0, mem_wdata}, {16'd0, e.data});
                    else      chk("rf_wdata", {16'd0, rf_wdata}, {16'd0, e.data});
                    void'(sbq.pop_front());
                end
            end
        end
    endtask

    task automatic do_op(input logic sm, input logic [7:0] m, input logic [15:0] b,
                         input int exp_cyc, input logic exp_pc, input int stall_n,
                         input logic hold_start);
        int  cyc;
        bit  done_seen;
        push_expected(sm, m, b);
        start = 1'b1; is_sm = sm; mask = m; base_addr = b; mem_ready = 1'b1;
        @(negedge clk);
        chk("idle_busy", {31'd0, busy}, 32'd0);
        monitor();
        @(posedge clk); #1;
        cyc = 1;
        done_seen = 0;
        while (!done_seen && cyc <= 40) begin
            start     = hold_start && (cyc == 1);
            mem_ready = (cyc <= stall_n) ? 1'b0 : 1'b1;
            @(negedge clk);
            monitor();
            chk("busy", {31'd0, busy}, 32'd1);
            if (done) begin
                done_seen = 1;
                chk("done_cycle", cyc, exp_cyc);
                chk("pc_loaded", {31'd0, pc_loaded}, {31'd0, exp_pc});
            end
            @(posedge clk); #1;
            cyc++;
        end
        chk("done_seen", {31'd0, done_seen}, 32'd1);
        start = 1'b0;
        mem_ready = 1'b1;
        @(negedge clk);
        chk("after_busy_done", {30'd0, busy, done}, 32'd0);
        monitor();
        chk("queue_empty", sbq.size(), 0);
        sbq.delete();
        @(posedge clk); #1;
    endtask

    logic [15:0] snap [8];

    initial begin
        rst = 1'b0; start = 1'b0; is_sm = 1'b0; mask = 8'h00;
        base_addr = 16'h0000; mem_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs",
            {7'd0, busy, done, pc_loaded, rf_wr_en, mem_rd_en, mem_wr_en, rf_addr, mem_addr}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;

        do_op(1'b0, 8'b1010_0110, 16'h0100, 5, 1'b0, 0, 1'b0);
        do_op(1'b1, 8'b0000_0111, 16'hFFFE, 4, 1'b0, 0, 1'b0);
        chk("sm_wrap_mem0", {16'd0, mem_val(16'h0000)}, {16'd0, rf_val(3'd2)});
        do_op(1'b0, 8'h01, 16'h0500, 4, 1'b1, 2, 1'b0);
        do_op(1'b0, 8'h00, 16'h0700, 1, 1'b0, 0, 1'b1);
        do_op(1'b0, 8'hFF, 16'h0400, 9, 1'b1, 0, 1'b0);

        // Reset in cycle 3 of an 8-register LM.
        for (int i = 0; i < 8; i++) snap[i] = rf_val(3'(i));
        push_expected(1'b0, 8'hFF, 16'h0200);
        start = 1'b1; is_sm = 1'b0; mask = 8'hFF; base_addr = 16'h0200; mem_ready = 1'b1;
        @(negedge clk); monitor();
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) begin
            @(negedge clk); monitor();
            @(posedge clk); #1;
        end
        rst = 1'b0;
        @(negedge clk);
        chk("rst_no_rf_write", {31'd0, rf_wr_en}, 32'd0);
        monitor();
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("post_rst_outputs",
                {7'd0, busy, done, pc_loaded, rf_wr_en, mem_rd_en, mem_wr_en, rf_addr, mem_addr}, 32'd0);
            monitor();
            @(posedge clk); #1;
        end
        chk("rst_remaining", sbq.size(), 6);
        sbq.delete();
        chk("rst_r0", {16'd0, rf_val(3'd0)}, {16'd0, pat(16'h0200)});
        chk("rst_r1", {16'd0, rf_val(3'd1)}, {16'd0, pat(16'h0201)});
        for (int i = 2; i < 8; i++) chk("rst_untouched", {16'd0, rf_val(3'(i))}, {16'd0, snap[i]});

        do_op(1'b0, 8'h06, 16'h0300, 3, 1'b0, 0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
